// File: rtl/dsc_mul_seq_if.sv
// Operand/result handshake bundle for dsc_mul_seq.
// master = upstream producer and downstream consumer side; slave = the sequencer.
interface dsc_mul_seq_if #(
    parameter int WIDTH = 8,
    parameter int ZW    = 3 * WIDTH,
    parameter int CW    = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [ZW-1:0]    out_z;
    logic [CW-1:0]    out_cycles;

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_z, out_cycles
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_z, out_cycles
    );
endinterface

// File: rtl/dsc_mul_seq.sv
// Sequencer that runs one dsc_mul operation per accepted operand triple and returns z with its cycle count.
// Optional DSC_MUL_SEQ_ZERO_BYPASS_EN: a zero operand skips the multiplier and returns z=0, cycles=0.
//
// state | meaning
// IDLE  | ready for a triple; multiplier held in reset
// CLEAR | one cycle of multiplier reset with the operands already stable; counter cleared
// RUN   | multiplier enabled, counting cycles until mul_ov
// DONE  | result presented, waiting for out_ready
module dsc_mul_seq #(
    parameter int WIDTH = 8,
    parameter int ZW    = 3 * WIDTH,
    parameter int CW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    dsc_mul_seq_if.slave     hs,
    output logic             mul_rst,
    output logic             mul_en,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_c,
    input  logic [ZW-1:0]    mul_z,
    input  logic             mul_ov,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [ZW-1:0] out_z_q;
    logic [CW-1:0] out_cycles_q;
    logic          accept;
    logic          zero_hit;

    assign accept   = (state == IDLE) && hs.in_valid;
    assign zero_hit = ZERO_BYPASS &&
                      ((hs.in_a == '0) || (hs.in_b == '0) || (hs.in_c == '0));
    // Saturating increment; the count never wraps back to a small value.
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs.in_valid) state_nxt = zero_hit ? DONE : CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN:     if (mul_ov) state_nxt = DONE;
            DONE:    if (hs.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a        <= '0;
            mul_b        <= '0;
            mul_c        <= '0;
            cnt          <= '0;
            out_z_q      <= '0;
            out_cycles_q <= '0;
        end else begin
            if (accept) begin
                mul_a <= hs.in_a;
                mul_b <= hs.in_b;
                mul_c <= hs.in_c;
                if (zero_hit) begin
                    out_z_q      <= '0;
                    out_cycles_q <= '0;
                end
            end
            if (state == CLEAR) begin
                cnt <= '0;
            end
            if (state == RUN) begin
                cnt <= cnt_inc;
                // cnt_inc already includes the ov cycle itself
                if (mul_ov) begin
                    out_z_q      <= mul_z;
                    out_cycles_q <= cnt_inc;
                end
            end
        end
    end

    assign hs.in_ready   = (state == IDLE);
    assign hs.out_valid  = (state == DONE);
    assign hs.out_z      = out_z_q;
    assign hs.out_cycles = out_cycles_q;
    assign mul_rst       = (state != RUN);
    assign mul_en        = (state == RUN);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq with a behavioural multiplier that raises ov after 20 enabled cycles.
module tb_dsc_mul_seq;
    localparam int WIDTH = 8;
    localparam int ZW    = 24;
    localparam int CW    = 32;
    localparam int N     = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsc_mul_seq_if #(.WIDTH(WIDTH), .ZW(ZW), .CW(CW)) hs ();

    logic             mul_rst;
    logic             mul_en;
    logic             mul_ov;
    logic             busy;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_c;
    logic [ZW-1:0]    mul_z;

    dsc_mul_seq #(.WIDTH(WIDTH), .ZW(ZW), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .hs      (hs),
        .mul_rst (mul_rst),
        .mul_en  (mul_en),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .mul_c   (mul_c),
        .mul_z   (mul_z),
        .mul_ov  (mul_ov),
        .busy    (busy)
    );

    // behavioural multiplier: ov during the N-th enabled cycle
    int run_cnt = 0;
    always @(posedge clk) begin
        if (mul_rst) run_cnt <= 0;
        else if (mul_en) run_cnt <= run_cnt + 1;
    end
    assign mul_ov = mul_en && (run_cnt == N - 1);
    assign mul_z  = ZW'(mul_a) * ZW'(mul_b) * ZW'(mul_c);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        @(negedge clk);
        chk("accept_in_ready", hs.in_ready, 1);
        hs.in_valid = 1'b1;
        hs.in_a     = a;
        hs.in_b     = b;
        hs.in_c     = c;
        @(posedge clk);
        #1 hs.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int waited, output int en_cnt, output bit ov_before);
        bit prev_ov;
        prev_ov   = 1'b0;
        waited    = 0;
        en_cnt    = 0;
        ov_before = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            waited++;
            if (hs.out_valid) begin
                ov_before = prev_ov;
                return;
            end
            if (mul_en) en_cnt++;
            prev_ov = mul_ov;
        end
        chk("result_timeout", hs.out_valid, 1);
    endtask

    int  waited;
    int  en_cnt;
    bit  ov_before;
    bit  seen;
    int  t1, t2, nres;
    logic [ZW-1:0] z1, z2;
    logic [CW-1:0] cyc2;

    initial begin
        hs.in_valid  = 1'b0;
        hs.in_a      = '0;
        hs.in_b      = '0;
        hs.in_c      = '0;
        hs.out_ready = 1'b0;

        // reset values while rst held
        #2;
        chk("rst_in_ready", hs.in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mul_rst", mul_rst, 1);
        chk("rst_mul_en", mul_en, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_out_valid", hs.out_valid, 0);
        chk("rst_out_z", hs.out_z, 0);
        chk("rst_out_cycles", hs.out_cycles, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", hs.in_ready, 1);

        // basic multiply 15*15*15
        accept(8'd15, 8'd15, 8'd15);
        wait_result(waited, en_cnt, ov_before);
        chk("basic_latency", waited, 22);
        chk("basic_en_cycles", en_cnt, 20);
        chk("basic_ov_then_valid", ov_before, 1);
        chk("basic_out_z", hs.out_z, 3375);
        chk("basic_out_cycles", hs.out_cycles, 20);
        chk("basic_mul_en_done", mul_en, 0);

        // backpressure with a stray input triple
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin
                hs.in_valid = 1'b1;
                hs.in_a = 8'd1;
                hs.in_b = 8'd2;
                hs.in_c = 8'd3;
            end else begin
                hs.in_valid = 1'b0;
            end
            chk("bp_out_valid", hs.out_valid, 1);
            chk("bp_in_ready", hs.in_ready, 0);
            chk("bp_out_z", hs.out_z, 3375);
            chk("bp_out_cycles", hs.out_cycles, 20);
            chk("bp_mul_a", mul_a, 15);
        end
        @(negedge clk);
        hs.in_valid = 1'b0;
        chk("bp_mul_a_final", mul_a, 15);
        hs.out_ready = 1'b1;
        @(posedge clk);
        #1 hs.out_ready = 1'b0;
        chk("bp_release_valid", hs.out_valid, 0);
        chk("bp_release_in_ready", hs.in_ready, 1);

        // async reset seven cycles into RUN
        accept(8'd9, 8'd9, 8'd9);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (mul_en) seen = 1'b1;
        end
        chk("mrst_run_reached", seen, 1);
        repeat (6) @(negedge clk);
        chk("mrst_still_running", mul_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_mul_en", mul_en, 0);
        chk("mrst_mul_rst", mul_rst, 1);
        chk("mrst_in_ready", hs.in_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_out_z", hs.out_z, 0);
        chk("mrst_mul_a", mul_a, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (hs.out_valid) seen = 1'b1;
        end
        chk("mrst_no_output", seen, 0);

        // streaming: constant valid/ready
        hs.out_ready = 1'b1;
        @(negedge clk);
        chk("stream_in_ready", hs.in_ready, 1);
        hs.in_valid = 1'b1;
        hs.in_a = 8'd255;
        hs.in_b = 8'd255;
        hs.in_c = 8'd255;
        @(posedge clk);
        #1;
        hs.in_a = 8'd3;
        hs.in_b = 8'd5;
        hs.in_c = 8'd7;
        nres = 0;
        t1 = 0;
        t2 = 0;
        z1 = '0;
        z2 = '0;
        cyc2 = '0;
        for (int t = 0; t < 200 && nres < 2; t++) begin
            @(negedge clk);
            if (hs.out_valid) begin
                if (nres == 0) begin
                    t1 = t;
                    z1 = hs.out_z;
                end else begin
                    t2 = t;
                    z2 = hs.out_z;
                    cyc2 = hs.out_cycles;
                    hs.in_valid = 1'b0;
                end
                nres++;
            end
        end
        chk("stream_results", nres, 2);
        chk("stream_z1", z1, 16581375);
        chk("stream_z2", z2, 105);
        chk("stream_cycles2", cyc2, 20);
        chk("stream_spacing", t2 - t1, N + 3);
        @(negedge clk);
        hs.out_ready = 1'b0;
        chk("stream_drained", busy, 0);

        // zero operand
        accept(8'd0, 8'd9, 8'd9);
        wait_result(waited, en_cnt, ov_before);
        chk("zero_mul_a", mul_a, 0);
        chk("zero_mul_b", mul_b, 9);
        chk("zero_out_z", hs.out_z, 0);
`ifdef DSC_MUL_SEQ_ZERO_BYPASS_EN
        chk("zero_latency", waited, 1);
        chk("zero_en_cycles", en_cnt, 0);
        chk("zero_out_cycles", hs.out_cycles, 0);
`else
        chk("zero_latency", waited, 22);
        chk("zero_en_cycles", en_cnt, 20);
        chk("zero_out_cycles", hs.out_cycles, 20);
`endif
        hs.out_ready = 1'b1;
        @(posedge clk);
        #1 hs.out_ready = 1'b0;
        chk("zero_release", hs.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
